pixel_channel_proc: RTL and testbench
=====================================

# pixel_channel_proc

Parametrised per-pixel channel processor for the raster video path. It sits between the timing generator and the display/capture stage, like the existing per-channel RGB wrappers. It applies one of four selectable point operations to N_CH channels of P_IMGDEPTH bits, carries the h/v raster counts through a fixed 2-cycle pipeline, and switches mode only on frame boundaries so a frame is never torn.

## Interface
- P_IMGDEPTH, 8, bits per channel
- N_CH, 3, channel count (3 = R,G,B), ≥1
- HEIGHT, 480, active lines per frame
- WIDTH, 640, active pixels per line

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  pixel qualifier
- h_count_in  in  $clog2(WIDTH+1)  pixel x
- v_count_in  in  $clog2(HEIGHT+1)  pixel y
- pix_in  in  N_CH*P_IMGDEPTH  channels packed, ch0 in LSBs
- mode_in  in  2  requested operation (pkg enum)
- thresh_in  in  P_IMGDEPTH  threshold for BINARIZE
- valid_out  out  1  output qualifier
- h_count_out  out  $clog2(WIDTH+1)  x aligned to pix_out
- v_count_out  out  $clog2(HEIGHT+1)  y aligned to pix_out
- pix_out  out  N_CH*P_IMGDEPTH  processed channels
- mode_out  out  2  mode applied to the current pix_out
- frame_done  out  1  1-cycle pulse with last pixel of frame

## Operation
- Modes, applied independently to every channel x:
  - BYPASS (0): x.
  - INVERT (1): (2^P_IMGDEPTH−1) − x.
  - BITREV (2): bit order reversed (bit i → bit P_IMGDEPTH−1−i).
  - BINARIZE (3): all-ones if x ≥ thresh, else 0.
- Frame-start pixel: valid_in=1 with h_count_in=0 and v_count_in=0.
- On the frame-start pixel, mode_in and thresh_in are latched into active_mode/active_thresh.
  - The frame-start pixel itself uses the newly sampled values.
  - All other pixels use the latched values; mode_in/thresh_in changes mid-frame are ignored.
- Pixels with valid_in=0 are not processed. They produce valid_out=0 two cycles later, and the pix/count outputs are held at their previous values.
- frame_done=1 with the output pixel where valid_out=1, h_count_out=WIDTH−1 and v_count_out=HEIGHT−1.
- Counts are passed through unchecked. Out-of-range counts are processed normally and never assert frame_done.

## Timing
- Latency is exactly 2 cycles, valid_in→valid_out, with a throughput of 1 pixel per cycle and no backpressure.
- Stage 1 registers pixel, counts, valid and effective mode/thresh. It also updates active_mode/active_thresh on the frame-start pixel.
- Stage 2 registers the operation result, counts, valid, mode_out and frame_done.
- Back-to-back frames are supported. A frame-start pixel immediately following the previous frame's last pixel latches correctly.
- Reset (async assert, sync release) drives the following to 0:
  - valid_out, frame_done, pix_out, h/v_count_out, mode_out;
  - all pipeline registers;
  - active_mode (BYPASS) and active_thresh.
- Reset mid-frame: in-flight pixels are discarded. After release, BYPASS applies until the next frame-start pixel.

## Structure
- Package pixel_proc_pkg holds:
  - typedef enum logic [1:0] {BYPASS, INVERT, BITREV, BINARIZE} pix_mode_e;
  - the mode width constant.
- Sub-module pixel_op is purely combinational: one channel, mode + thresh + x → y.
  - It is instantiated N_CH times via generate.
  - The top holds the mode latch, the pipeline registers and the frame_done compare.

## Test plan
- Reset, then BYPASS, P_IMGDEPTH=8, N_CH=3: pix_in 0x123456 at (5,7) → pix_out 0x123456, counts (5,7), valid_out exactly 2 cycles later, mode_out=0.
- INVERT/BITREV: frame start with mode_in=1, then 0x00FF0F → 0xFF00F0. Next frame with mode_in=2, then ch0=0x01 → 0x80 and ch0=0xA0 → 0x05.
- BINARIZE with thresh_in=0x80: channels 0x7F/0x80/0xFF → 0x00/0xFF/0xFF. Changing thresh_in to 0x00 mid-frame does not alter results until the next frame start.
- Mid-frame mode_in change from 1 to 2 takes effect exactly at the next (0,0) valid pixel. A valid_in gap yields matching valid_out gaps with held data.
- Small frame (WIDTH=4, HEIGHT=2), two consecutive frames: frame_done pulses once per frame, coincident with output (3,1).
- Assert rst mid-frame in INVERT: all outputs go to 0 immediately. After release, pixels pass in BYPASS until a frame start with mode_in=1.

Source files
------------

// File: rtl/pixel_proc_pkg.sv
// Shared types for the per-pixel channel processor: operation modes and their width.
package pixel_proc_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BYPASS   = 2'd0,
    INVERT   = 2'd1,
    BITREV   = 2'd2,
    BINARIZE = 2'd3
  } pix_mode_e;
endpackage

// File: rtl/pixel_op.sv
// Single-channel point operation; purely combinational, one instance per channel.
module pixel_op
  import pixel_proc_pkg::*;
#(
  parameter int W = 8
) (
  input  pix_mode_e      mode,
  input  logic [W-1:0]   thresh,
  input  logic [W-1:0]   x,
  output logic [W-1:0]   y
);
  always_comb begin
    y = x;
    case (mode)
      BYPASS:   y = x;
      INVERT:   y = ~x;
      BITREV:   for (int i = 0; i < W; i++) y[i] = x[W-1-i];
      BINARIZE: y = {W{x >= thresh}};
      default:  y = x;
    endcase
  end
endmodule

// File: rtl/pixel_channel_proc.sv
// N-channel point-operation stage with a 2-cycle pipeline; mode/threshold are
// captured only on the frame-start pixel so a frame is never processed with mixed settings.
module pixel_channel_proc
  import pixel_proc_pkg::*;
#(
  parameter int P_IMGDEPTH = 8,
  parameter int N_CH       = 3,
  parameter int HEIGHT     = 480,
  parameter int WIDTH      = 640
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [$clog2(WIDTH+1)-1:0]   h_count_in,
  input  logic [$clog2(HEIGHT+1)-1:0]  v_count_in,
  input  logic [N_CH*P_IMGDEPTH-1:0]   pix_in,
  input  logic [MODE_W-1:0]            mode_in,
  input  logic [P_IMGDEPTH-1:0]        thresh_in,
  output logic                         valid_out,
  output logic [$clog2(WIDTH+1)-1:0]   h_count_out,
  output logic [$clog2(HEIGHT+1)-1:0]  v_count_out,
  output logic [N_CH*P_IMGDEPTH-1:0]   pix_out,
  output logic [MODE_W-1:0]            mode_out,
  output logic                         frame_done
);
  localparam int HW     = $clog2(WIDTH+1);
  localparam int VW     = $clog2(HEIGHT+1);
  localparam int STAGES = 2;
  localparam logic [HW-1:0] LAST_H = HW'(WIDTH-1);
  localparam logic [VW-1:0] LAST_V = VW'(HEIGHT-1);

  typedef logic [N_CH-1:0][P_IMGDEPTH-1:0] pix_t;

  logic [STAGES-1:0]     vld_pipe;
  pix_mode_e             act_mode, eff_mode, mode1;
  logic [P_IMGDEPTH-1:0] act_thr, eff_thr, thr1;
  pix_t                  pix1, res;
  logic [HW-1:0]         h1;
  logic [VW-1:0]         v1;
  logic                  frame_start;

  // The frame-start pixel must see its own freshly sampled settings.
  assign frame_start = valid_in && (h_count_in == '0) && (v_count_in == '0);
  assign eff_mode    = frame_start ? pix_mode_e'(mode_in) : act_mode;
  assign eff_thr     = frame_start ? thresh_in : act_thr;

  // Stage 1: capture pixel, counts and the settings it will be processed with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      pix1     <= '0;
      h1       <= '0;
      v1       <= '0;
      mode1    <= BYPASS;
      thr1     <= '0;
      act_mode <= BYPASS;
      act_thr  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], valid_in};
      if (valid_in) begin
        pix1  <= pix_t'(pix_in);
        h1    <= h_count_in;
        v1    <= v_count_in;
        mode1 <= eff_mode;
        thr1  <= eff_thr;
      end
      if (frame_start) begin
        act_mode <= pix_mode_e'(mode_in);
        act_thr  <= thresh_in;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pixel_op #(.W(P_IMGDEPTH)) u_op (
      .mode   (mode1),
      .thresh (thr1),
      .x      (pix1[c]),
      .y      (res[c])
    );
  end

  // Stage 2: outputs hold their last values across invalid cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out     <= '0;
      h_count_out <= '0;
      v_count_out <= '0;
      mode_out    <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= vld_pipe[0] && (h1 == LAST_H) && (v1 == LAST_V);
      if (vld_pipe[0]) begin
        pix_out     <= res;
        h_count_out <= h1;
        v_count_out <= v1;
        mode_out    <= mode1;
      end
    end
  end

  assign valid_out = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_pixel_channel_proc.sv
// Directed bench: a 640x480 instance for the point operations and a 4x2 instance
// for frame_done; every driven cycle pushes the expected output due two cycles later.
module tb_pixel_channel_proc;
  localparam int MH = $clog2(641), MV = $clog2(481);
  localparam int SH = $clog2(5),   SV = $clog2(3);

  logic clk = 0, rst = 0;
  logic valid_in = 0, valid_s = 0;
  logic [MH-1:0] h_in = 0;
  logic [MV-1:0] v_in = 0;
  logic [SH-1:0] hs_in = 0;
  logic [SV-1:0] vs_in = 0;
  logic [23:0] pix_in = 0;
  logic [1:0]  mode_in = 0;
  logic [7:0]  thresh_in = 0;

  logic          m_vld, m_fd, s_vld, s_fd;
  logic [MH-1:0] m_h;
  logic [MV-1:0] m_v;
  logic [SH-1:0] s_h;
  logic [SV-1:0] s_v;
  logic [23:0]   m_pix, s_pix;
  logic [1:0]    m_mode, s_mode;

  int checks = 0, errors = 0, cyc = 0;

  pixel_channel_proc dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .h_count_in(h_in), .v_count_in(v_in),
    .pix_in(pix_in), .mode_in(mode_in), .thresh_in(thresh_in), .valid_out(m_vld),
    .h_count_out(m_h), .v_count_out(m_v), .pix_out(m_pix), .mode_out(m_mode),
    .frame_done(m_fd)
  );

  pixel_channel_proc #(.HEIGHT(2), .WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .valid_in(valid_s), .h_count_in(hs_in), .v_count_in(vs_in),
    .pix_in(pix_in), .mode_in(mode_in), .thresh_in(thresh_in), .valid_out(s_vld),
    .h_count_out(s_h), .v_count_out(s_v), .pix_out(s_pix), .mode_out(s_mode),
    .frame_done(s_fd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    bit          sel;
    bit          vld;
    logic [23:0] pix;
    int          h, v;
    logic [1:0]  mode;
    bit          fd;
  } exp_t;

  exp_t q[$];

  // Reference model state, indexed by instance (0 = 640x480, 1 = 4x2).
  logic [1:0]  am[2];
  logic [7:0]  at[2];
  logic [23:0] hp[2];
  int          hh[2], hv[2];
  logic [1:0]  hm[2];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] op(input logic [1:0] m, input logic [7:0] t, input logic [7:0] x);
    logic [7:0] r;
    case (m)
      2'd1: r = 8'hFF - x;
      2'd2: for (int i = 0; i < 8; i++) r[7-i] = x[i];
      2'd3: r = (x >= t) ? 8'hFF : 8'h00;
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      am[i] = 0; at[i] = 0; hp[i] = 0; hh[i] = 0; hv[i] = 0; hm[i] = 0;
    end
  endtask

  task automatic drive(input bit sel, input bit v, input int h, input int vc,
                       input logic [23:0] p, input logic [1:0] m, input logic [7:0] t);
    exp_t e;
    logic [1:0] em;
    logic [7:0] et;
    bit fs;
    valid_in = sel ? 1'b0 : v;
    valid_s  = sel ? v : 1'b0;
    if (sel) begin hs_in = SH'(h); vs_in = SV'(vc); end
    else begin h_in = MH'(h); v_in = MV'(vc); end
    pix_in = p; mode_in = m; thresh_in = t;
    e.fd = 0;
    if (v) begin
      fs = (h == 0) && (vc == 0);
      if (fs) begin am[sel] = m; at[sel] = t; end
      em = am[sel]; et = at[sel];
      for (int c = 0; c < 3; c++) hp[sel][c*8 +: 8] = op(em, et, p[c*8 +: 8]);
      hh[sel] = h; hv[sel] = vc; hm[sel] = em;
      e.fd = sel ? (h == 3 && vc == 1) : (h == 639 && vc == 479);
    end
    e.due = cyc + 2; e.sel = sel; e.vld = v; e.pix = hp[sel];
    e.h = hh[sel]; e.v = hv[sel]; e.mode = hm[sel];
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_in = 0; valid_s = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) chk("late_entry", e.due, cyc);
      else if (e.sel) begin
        chk("s_valid", s_vld, e.vld);
        chk("s_pix", s_pix, e.pix);
        chk("s_h", s_h, e.h);
        chk("s_v", s_v, e.v);
        chk("s_mode", s_mode, e.mode);
        chk("s_frame_done", s_fd, e.fd);
      end else begin
        chk("m_valid", m_vld, e.vld);
        chk("m_pix", m_pix, e.pix);
        chk("m_h", m_h, e.h);
        chk("m_v", m_v, e.v);
        chk("m_mode", m_mode, e.mode);
        chk("m_frame_done", m_fd, e.fd);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_m_valid", m_vld, 0);
    chk("rst_m_pix", m_pix, 0);
    chk("rst_m_mode", m_mode, 0);
    chk("rst_m_fd", m_fd, 0);
    chk("rst_s_valid", s_vld, 0);
    chk("rst_s_counts", {s_h, s_v}, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // BYPASS after reset, with invalid cycles around it to pin the latency.
    drive(0, 0, 0, 0, 24'h0, 2'd0, 8'h00);
    drive(0, 1, 5, 7, 24'h123456, 2'd0, 8'h00);
    drive(0, 0, 9, 9, 24'hABCDEF, 2'd0, 8'h00);
    drive(0, 0, 9, 9, 24'hABCDEF, 2'd0, 8'h00);

    // INVERT frame; mode_in change mid-frame is ignored.
    drive(0, 1, 0, 0, 24'h00FF0F, 2'd1, 8'h00);
    drive(0, 1, 1, 0, 24'h00FF0F, 2'd0, 8'h00);
    // BITREV frame.
    drive(0, 1, 0, 0, 24'h000001, 2'd2, 8'h00);
    drive(0, 1, 1, 0, 24'h0000A0, 2'd1, 8'h00);
    // BINARIZE at 0x80, then threshold change mid-frame and a valid gap.
    drive(0, 1, 0, 0, 24'hFF807F, 2'd3, 8'h80);
    drive(0, 1, 1, 0, 24'h00107F, 2'd3, 8'h00);
    drive(0, 0, 2, 0, 24'hFFFFFF, 2'd3, 8'h00);
    drive(0, 0, 2, 0, 24'hFFFFFF, 2'd3, 8'h00);
    drive(0, 1, 2, 0, 24'h7F8001, 2'd3, 8'h00);
    drive(0, 1, 0, 0, 24'h00107F, 2'd3, 8'h00);
    // INVERT frame with mode_in=2 requested mid-frame; takes effect at next (0,0).
    drive(0, 1, 0, 0, 24'h123456, 2'd1, 8'h00);
    drive(0, 1, 1, 0, 24'h00FF0F, 2'd2, 8'h00);
    drive(0, 1, 2, 0, 24'h000001, 2'd2, 8'h00);
    drive(0, 1, 0, 0, 24'h0000A0, 2'd2, 8'h00);
    // Last pixel of a full-size frame and out-of-range counts.
    drive(0, 1, 639, 479, 24'h010203, 2'd0, 8'h00);
    drive(0, 1, 640, 480, 24'h040506, 2'd0, 8'h00);
    drive(0, 1, 639, 478, 24'h070809, 2'd0, 8'h00);
    idle(3);

    // Two back-to-back 4x2 frames on the small instance.
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 4; x++)
          drive(1, 1, x, y, 24'(32'h00102030 + x * 32'h01010101 + y * 32'h00404040 + f),
                2'(f + 1), 8'h00);
    idle(3);

    // Reset mid-frame in INVERT: outputs clear immediately, BYPASS until next frame start.
    drive(0, 1, 0, 0, 24'h112233, 2'd1, 8'h00);
    drive(0, 1, 1, 0, 24'h445566, 2'd1, 8'h00);
    drive(0, 1, 2, 0, 24'h778899, 2'd1, 8'h00);
    rst = 0;
    #1;
    chk("midrst_valid", m_vld, 0);
    chk("midrst_pix", m_pix, 0);
    chk("midrst_counts", {m_h, m_v}, 0);
    chk("midrst_mode", m_mode, 0);
    chk("midrst_fd", m_fd, 0);
    q.delete();
    model_reset();
    valid_in = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    drive(0, 1, 3, 0, 24'h00FF0F, 2'd1, 8'h00);
    drive(0, 1, 0, 0, 24'h00FF0F, 2'd1, 8'h00);
    drive(0, 1, 1, 0, 24'h123456, 2'd0, 8'h00);
    idle(4);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
